// File: rtl/aes_dec.sv
// ---------------------------------------------------------------------------
// aes_dec -- iterative AES-128 decryption core.
//
// Expands the round-0 key forward to round 10 (ten cycles). It then performs
// the inverse cipher at one round per clock. The round key is rolled
// backwards on the fly, so only one 128-bit key register is needed.
//
// Byte order: FIPS-197 byte 0 sits in bits [127:120]. The layout is
// column-major, so byte index = 4*column + row.
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst    asynchronous active-high reset
//   i_start  request pulse, sampled only in IDLE or DONE
//   i_din    128-bit ciphertext, sampled on the accepting edge
//   i_keyin  128-bit cipher key (round-0 key), sampled on the accepting edge
//   o_dout   state register; holds the plaintext while o_done = 1
//   o_done   result valid (level), held until the next accepted start
//   o_busy   high from the accepted start until o_done rises
// ---------------------------------------------------------------------------
module aes_dec (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_din,
    input  logic [127:0] i_keyin,
    output logic [127:0] o_dout,
    output logic         o_done,
    output logic         o_busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY_EXP  = 3'd1,
        S_INIT_ADD = 3'd2,
        S_ROUND    = 3'd3,
        S_FINAL    = 3'd4,
        S_DONE     = 3'd5
    } fsm_t;

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_rnd;
    logic         r_done;
    logic         r_busy;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, modulo x^8 + x^4 + x^3 + x + 1 (0x11b)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = xtime(aa);
        end
        return p;
    endfunction

    // The multiplicative inverse is computed as x^254 = x^(2+4+...+128).
    // Each pass squares p and accumulates it. inv(0) falls out as 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    // ------------------------------------------------------------------
    // Key schedule helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ {rc, 0, 0, 0}
    function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])}
               ^ {rc, 24'h000000};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w4, w5, w6, w7;
        w4 = k[127:96] ^ key_core(k[31:0], rc);
        w5 = k[95:64] ^ w4;
        w6 = k[63:32] ^ w5;
        w7 = k[31:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    // The previous round key is recovered from the current one. w3 must be
    // rebuilt first because it feeds the SubWord term of w0.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[63:32] ^ k[31:0];
        w2 = k[95:64] ^ k[63:32];
        w1 = k[127:96] ^ k[95:64];
        w0 = k[127:96] ^ key_core(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // ------------------------------------------------------------------
    // Inverse round transforms
    // ------------------------------------------------------------------
    // Row r is rotated right by r bytes: out[r][c] = in[r][(c - r) mod 4]
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Shared datapath. The same rcon[rnd] serves both the forward
    // expansion in KEY_EXP and the backward roll in ROUND/FINAL.
    // ------------------------------------------------------------------
    logic [7:0]   w_rcon;
    logic [127:0] w_key_next;
    logic [127:0] w_key_prev;
    logic [127:0] w_ark;
    logic [127:0] w_imc;

    assign w_rcon     = rcon(r_rnd);
    assign w_key_next = fwd_step(r_key, w_rcon);
    assign w_key_prev = inv_step(r_key, w_rcon);
    assign w_ark      = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_key_prev;
    assign w_imc      = inv_mix_columns(w_ark);

    // Control FSM plus the state, key, round and status registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm   <= S_IDLE;
            r_state <= 128'h0;
            r_key   <= 128'h0;
            r_rnd   <= 4'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= i_din;
                        r_key   <= i_keyin;
                        r_rnd   <= 4'd1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_fsm   <= S_KEY_EXP;
                    end else begin
                        r_fsm   <= r_fsm;
                    end
                end
                S_KEY_EXP: begin
                    r_key <= w_key_next;
                    if (r_rnd == 4'd10) begin
                        r_fsm <= S_INIT_ADD;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                S_INIT_ADD: begin
                    r_state <= r_state ^ r_key;
                    r_rnd   <= 4'd10;
                    r_fsm   <= S_ROUND;
                end
                S_ROUND: begin
                    r_state <= w_imc;
                    r_key   <= w_key_prev;
                    r_rnd   <= r_rnd - 4'd1;
                    if (r_rnd == 4'd2) begin
                        r_fsm <= S_FINAL;
                    end else begin
                        r_fsm <= S_ROUND;
                    end
                end
                S_FINAL: begin
                    r_state <= w_ark;
                    r_key   <= w_key_prev;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_fsm   <= S_DONE;
                end
                default: begin
                    r_fsm  <= S_IDLE;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_dout = r_state;
    assign o_done = r_done;
    assign o_busy = r_busy;

endmodule

// File: doc/aes_dec.md
# aes_dec

Iterative AES-128 decryption core, the inverse counterpart to the team's AES-128 encryption core. It accepts a 128-bit ciphertext and the 128-bit cipher key (round-0 key), expands the key forward to round 10 on chip, then runs the ten inverse rounds, one round per clock, rolling the round key backwards. It sits beside the encryption core on the same clock and reset and shares its byte-order conventions.

## Interface
- No parameters; AES-128 only.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- din  input  128  ciphertext; FIPS-197 byte 0 = din[127:120], column-major
- keyin  input  128  cipher key (round-0 key), same byte order
- dout  output  128  internal state register; plaintext when done=1
- done  output  1  result valid; level, held until next accepted start
- busy  output  1  high from accepted start until done rises

## Operation
- Registers: state[127:0], key[127:0], rnd[3:0], FSM {IDLE, KEY_EXP, INIT_ADD, ROUND, FINAL, DONE}.
- IDLE/DONE, start=1: state <= din, key <= keyin, rnd <= 1, busy <= 1, done <= 0, go KEY_EXP. start=0: hold.
- KEY_EXP: key <= fwd_step(key, rcon[rnd]); at rnd=10 go INIT_ADD, else rnd++. Leaves key = k10.
- INIT_ADD: state <= state ^ key; rnd <= 10; go ROUND.
- ROUND (rnd = 10..2): k' = inv_step(key, rcon[rnd]) (= k_{rnd-1}); state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k'); key <= k'; rnd--; after rnd=2 go FINAL.
- FINAL (rnd=1): k0 = inv_step(key, rcon[1]); state <= InvSubBytes(InvShiftRows(state)) ^ k0; key <= k0; busy <= 0; done <= 1; go DONE.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, applied to the top byte of the rotated word.
- fwd_step: w4 = w0 ^ SubWord(RotWord(w3)) ^ rcon; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
- inv_step (given w4..w7): w3 = w6^w7; w2 = w5^w6; w1 = w4^w5; w0 = w4 ^ SubWord(RotWord(w3)) ^ rcon.
- S-box computed, no lookup tables: sbox(x) = affine(inv(x)), inv_sbox(x) = inv(inv_affine(x)), inv = x^254 in GF(2^8) mod 0x11b, inv(0)=0; affine constant 0x63, inverse-affine constant 0x05.
- InvMixColumns: per column, coefficients {0e,0b,0d,09}, GF(2^8) multiply mod 0x11b.
- InvShiftRows: row r rotated right by r bytes.
- start while busy=1: ignored, no effect.

## Timing
- Reset (async, any state): FSM=IDLE, state=0, key=0, rnd=0, dout=0, done=0, busy=0. Mid-operation reset aborts with no partial output.
- Start accepted on edge E0; busy=1 after E0.
- KEY_EXP edges E1–E10, INIT_ADD E11, ROUND E12–E20, FINAL E21.
- After E21: done=1, busy=0, dout = plaintext. Latency: 21 edges after the accepting edge.
- In DONE, dout and done hold indefinitely; a new start at E0' drops done after E0' and restarts the sequence; dout is invalid until the next done.
- din and keyin are sampled only on the accepting edge; later changes have no effect.

## Test plan
- FIPS-197 C.1: keyin=000102030405060708090a0b0c0d0e0f, din=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done exactly 21 edges after accept, dout=00112233445566778899aabbccddeeff; internal key after E10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 B: keyin=2b7e151628aed2a6abf7158809cf4f3c, din=3925841d02dc09fbdc118597196a0b32 -> dout=3243f6a8885a308d313198a2e0370734; k10 = d014f9a8c9ee2589e13f0cc8b6630ca6; key after FINAL = keyin.
- Back-to-back: C.1 then B, second start issued while in DONE -> done drops after accept, second result correct; start pulses during busy ignored, result unchanged.
- Reset mid-run: assert rst at E15 -> immediately done=0, busy=0, dout=0; new C.1 start after release -> correct plaintext.
- Loopback: 50 random key/plaintext pairs encrypted by the encryption core, ciphertext fed to aes_dec -> dout equals original plaintext every time.
